joltage_stream_solver: RTL
==========================

Name: joltage_stream_solver

Overview:
- Parametrised successor to the fixed-bank battery solver. Accepts an ASCII byte stream of digit banks over a valid/ready handshake.
- Banks are variable-length and newline-delimited, up to MAX_BATS_PER_BANK digits each.
- For each bank, selects the lexicographically largest ordered subsequence of K digits, forms its decimal value, and accumulates the sum into Answer.
- Sits between the input byte source (ROM reader or UART FIFO) and the result/status reporting logic.

Parameters:
- K, 12, digits selected per bank (1..16; 2 gives part 1, 12 gives part 2).
- MAX_BATS_PER_BANK, 128, bank buffer depth in digits (must be >= K).
- BANK_BITS, 4*K+8, width of the per-bank value register (must hold 10^K-1).
- ANSWER_BITS, 64, width of the running total.

Ports:
- Clk  in  1  clock, all state on rising edge.
- RstN  in  1  asynchronous active-low reset.
- InValid  in  1  InData holds a byte.
- InData  in  8  ASCII byte.
- InReady  out  1  block can accept a byte; transfer occurs when InValid&&InReady.
- Answer  out  ANSWER_BITS  running total of bank values.
- BankCount  out  16  number of banks accumulated.
- Overflow  out  1  sticky; set when a total addition carries out of ANSWER_BITS.
- Error  out  1  sticky protocol error.
- Done  out  1  high after end of stream has been fully processed.

Behaviour:
- Reset (async, RstN=0): FSM=S_FILL, Len=0, Joltage[]=0, Bank=0, Answer=0, BankCount=0, Overflow=0, Error=0, Done=0. InReady is 1 in the first cycle after release.
- InReady=1 only in S_FILL. Bytes are consumed only on handshake. No state change when InValid=0.
- S_FILL, per accepted byte:
  - '0'..'9' (0x30-0x39): Buf[Len] <= digit, Len++. If Len==MAX_BATS_PER_BANK before the write -> S_ERROR.
  - 0x0D: ignored.
  - 0x0A with Len==0: ignored (blank line).
  - 0x0A with 0<Len<K: -> S_ERROR.
  - 0x0A with Len>=K: Idx=0, Joltage[]=0, -> S_SELECT.
  - 0x04 (EOT): if Len==0 -> S_DONE. If Len>=K, process the bank as for 0x0A, then go to S_DONE instead of S_FILL. If 0<Len<K -> S_ERROR.
  - Any other byte: -> S_ERROR.
- S_SELECT, one digit per cycle, Idx = 0..Len-1:
  - d=Buf[Idx]; MinPlace = (Idx >= Len-K) ? Idx-(Len-K) : 0.
  - Scan places i = MinPlace..K-1. At the first i with d > Joltage[i], set Joltage[i]=d and set every later place to 0. Places below MinPlace are untouched.
  - After Idx==Len-1: P=0, Bank=0, -> S_PACK.
- S_PACK, K cycles: Bank <= Bank*10 + Joltage[P], with *10 implemented as (x<<3)+(x<<1). P++.
- S_ACCUM, 1 cycle:
  - Answer += Bank, modulo 2^ANSWER_BITS; a carry-out sets Overflow.
  - BankCount++ (wraps at 2^16). Len=0.
  - -> S_FILL, or -> S_DONE if the bank was EOT-terminated.
- Latency: the terminating byte is accepted in cycle t; Answer/BankCount update at edge t+Len+K+2. InReady is low from t+1 until the return to S_FILL.
- S_DONE: Done=1, InReady=0; held until reset.
- S_ERROR: Error=1, InReady=0. Answer/BankCount freeze at their last accumulated value (a partial bank is discarded). Held until reset.
- Reset mid-bank (any state): all state cleared immediately; buffered digits are lost.
- Done and Error are never both 1.

Test Plan:
- K=2, banks "987654321111111", "811111111111119", "234234234234278", "818181911112111", then EOT -> per-bank 98, 89, 78, 92; Answer=357, BankCount=4, Done=1.
- K=12, same four banks -> 987654321111, 811111111119, 434234234278, 888911112111; Answer=3121910778619, BankCount=4.
- K=2, "12\r\n\n39" then EOT with no trailing newline -> CR and blank line ignored; Answer=12+39=51, BankCount=2, Done=1.
- K=2, InValid toggled randomly with backpressure checked -> no byte lost or duplicated; Answer=357 on the 4-bank stream. Assert InReady=0 throughout S_SELECT/S_PACK/S_ACCUM.
- Errors, separate runs with K=3:
  - "12\n" -> Error=1, Answer=0.
  - "12a" -> Error=1.
  - MAX_BATS_PER_BANK+1 digits -> Error=1.
  - In every case InReady stays 0 and Done stays 0 afterwards.
- ANSWER_BITS=8, K=2, banks "99","99","99" -> Answer=297 mod 256=41, Overflow=1. Assert RstN low mid-S_SELECT -> all outputs 0 asynchronously and InReady=1 after release.

Source files
------------

// File: rtl/joltage_stream_solver.sv
// joltage_stream_solver
// ---------------------------------------------------------------------------
// Consumes an ASCII stream of newline-delimited digit banks over a valid/ready
// handshake. For each bank it picks the lexicographically largest ordered
// subsequence of K digits, packs it into a decimal value and adds it to a
// running total.
//
// Ports:
//   Clk        in   clock, all state on rising edge
//   RstN       in   asynchronous active-low reset
//   InValid    in   InData holds a byte
//   InData     in   [7:0] ASCII byte
//   InReady    out  byte accepted when InValid && InReady (only while filling)
//   Answer     out  [ANSWER_BITS-1:0] running total of bank values
//   BankCount  out  [15:0] number of banks accumulated
//   Overflow   out  sticky, total addition carried out of ANSWER_BITS
//   Error      out  sticky protocol error
//   Done       out  end of stream fully processed
// ---------------------------------------------------------------------------
module joltage_stream_solver #(
  parameter int K                 = 12,
  parameter int MAX_BATS_PER_BANK = 128,
  parameter int BANK_BITS         = 4*K+8,
  parameter int ANSWER_BITS       = 64
) (
  input  logic                   Clk,
  input  logic                   RstN,
  input  logic                   InValid,
  input  logic [7:0]             InData,
  output logic                   InReady,
  output logic [ANSWER_BITS-1:0] Answer,
  output logic [15:0]            BankCount,
  output logic                   Overflow,
  output logic                   Error,
  output logic                   Done
);

  localparam int LEN_W  = $clog2(MAX_BATS_PER_BANK + 1);
  localparam int BUF_AW = (MAX_BATS_PER_BANK > 1) ? $clog2(MAX_BATS_PER_BANK) : 1;
  localparam int BUF_D  = 1 << BUF_AW;
  localparam int P_W    = (K > 1) ? $clog2(K) : 1;
  localparam int SUM_W  = ((ANSWER_BITS > BANK_BITS) ? ANSWER_BITS : BANK_BITS) + 1;

  typedef enum logic [2:0] {
    S_FILL   = 3'd0,
    S_SELECT = 3'd1,
    S_PACK   = 3'd2,
    S_ACCUM  = 3'd3,
    S_DONE   = 3'd4,
    S_ERROR  = 3'd5
  } state_t;

  state_t                 state_r;
  state_t                 state_next_s;
  logic [LEN_W-1:0]       len_r;
  logic [LEN_W-1:0]       idx_r;
  logic [P_W-1:0]         p_r;
  logic [3:0]             buf_r [BUF_D];
  logic [3:0]             jolt_r [K];
  logic [3:0]             jolt_next_s [K];
  logic [BANK_BITS-1:0]   bank_r;
  logic [ANSWER_BITS-1:0] answer_r;
  logic [15:0]            bank_count_r;
  logic                   overflow_r;
  logic                   error_r;
  logic                   done_r;
  logic                   in_ready_r;
  logic                   eot_r;

  logic                   accept_s;
  logic                   is_digit_s;
  logic                   len_zero_s;
  logic                   len_ge_k_s;
  logic                   len_full_s;
  logic                   last_idx_s;
  logic                   last_place_s;
  logic                   buf_wr_s;
  logic                   start_sel_s;
  logic                   eot_set_s;
  logic                   found_s;
  logic [3:0]             digit_s;
  logic [3:0]             sel_digit_s;
  logic [LEN_W-1:0]       len_minus_k_s;
  logic [LEN_W-1:0]       min_place_s;
  logic [SUM_W-1:0]       sum_s;

  // Byte classification, bank position flags and the accumulate adder
  always_comb begin
    accept_s      = InValid && in_ready_r;
    is_digit_s    = (InData >= 8'h30) && (InData <= 8'h39);
    digit_s       = InData[3:0];
    len_zero_s    = (len_r == LEN_W'(0));
    len_ge_k_s    = (len_r >= LEN_W'(K));
    len_full_s    = (len_r == LEN_W'(MAX_BATS_PER_BANK));
    last_idx_s    = (idx_r == (len_r - LEN_W'(1)));
    last_place_s  = (p_r == P_W'(K - 1));
    sel_digit_s   = buf_r[idx_r[BUF_AW-1:0]];
    len_minus_k_s = len_r - LEN_W'(K);
    // A digit this close to the end of the bank must leave room for the
    // remaining digits, so it may only land at place MinPlace or later.
    if (idx_r >= len_minus_k_s) begin
      min_place_s = idx_r - len_minus_k_s;
    end else begin
      min_place_s = LEN_W'(0);
    end
    sum_s = SUM_W'(answer_r) + SUM_W'(bank_r);
  end

  // Greedy placement: first eligible place the digit beats wins, later places clear
  always_comb begin
    found_s = 1'b0;
    for (int i = 0; i < K; i++) begin
      jolt_next_s[i] = jolt_r[i];
      if (LEN_W'(i) < min_place_s) begin
        jolt_next_s[i] = jolt_r[i];
      end else if (found_s) begin
        jolt_next_s[i] = 4'd0;
      end else if (sel_digit_s > jolt_r[i]) begin
        jolt_next_s[i] = sel_digit_s;
        found_s        = 1'b1;
      end else begin
        jolt_next_s[i] = jolt_r[i];
      end
    end
  end

  // Next-state logic and per-byte control strobes
  always_comb begin
    state_next_s = state_r;
    buf_wr_s     = 1'b0;
    start_sel_s  = 1'b0;
    eot_set_s    = 1'b0;
    case (state_r)
      S_FILL: begin
        if (!accept_s) begin
          state_next_s = S_FILL;
        end else if (is_digit_s) begin
          if (len_full_s) begin
            state_next_s = S_ERROR;
          end else begin
            buf_wr_s = 1'b1;
          end
        end else if (InData == 8'h0D) begin
          state_next_s = S_FILL;
        end else if ((InData == 8'h0A) || (InData == 8'h04)) begin
          if (len_zero_s) begin
            state_next_s = (InData == 8'h04) ? S_DONE : S_FILL;
          end else if (len_ge_k_s) begin
            start_sel_s  = 1'b1;
            eot_set_s    = (InData == 8'h04);
            state_next_s = S_SELECT;
          end else begin
            state_next_s = S_ERROR;
          end
        end else begin
          state_next_s = S_ERROR;
        end
      end
      S_SELECT: begin
        if (last_idx_s) begin
          state_next_s = S_PACK;
        end else begin
          state_next_s = S_SELECT;
        end
      end
      S_PACK: begin
        if (last_place_s) begin
          state_next_s = S_ACCUM;
        end else begin
          state_next_s = S_PACK;
        end
      end
      S_ACCUM: begin
        if (eot_r) begin
          state_next_s = S_DONE;
        end else begin
          state_next_s = S_FILL;
        end
      end
      S_DONE:  state_next_s = S_DONE;
      S_ERROR: state_next_s = S_ERROR;
      default: state_next_s = S_ERROR;
    endcase
  end

  // FSM state register
  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      state_r <= S_FILL;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Handshake and status flags registered from the next state
  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      in_ready_r <= 1'b1;
      done_r     <= 1'b0;
      error_r    <= 1'b0;
    end else begin
      in_ready_r <= (state_next_s == S_FILL);
      done_r     <= (state_next_s == S_DONE);
      error_r    <= (state_next_s == S_ERROR);
    end
  end

  // Digit buffer; only entries below Len are ever read, so it needs no reset
  always_ff @(posedge Clk) begin
    if (buf_wr_s) begin
      buf_r[len_r[BUF_AW-1:0]] <= digit_s;
    end
  end

  // Selection, packing and accumulation datapath
  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      len_r        <= LEN_W'(0);
      idx_r        <= LEN_W'(0);
      p_r          <= P_W'(0);
      bank_r       <= BANK_BITS'(0);
      answer_r     <= ANSWER_BITS'(0);
      bank_count_r <= 16'd0;
      overflow_r   <= 1'b0;
      eot_r        <= 1'b0;
      for (int i = 0; i < K; i++) begin
        jolt_r[i] <= 4'd0;
      end
    end else begin
      case (state_r)
        S_FILL: begin
          if (buf_wr_s) begin
            len_r <= len_r + LEN_W'(1);
          end
          if (start_sel_s) begin
            idx_r <= LEN_W'(0);
            eot_r <= eot_set_s;
            for (int i = 0; i < K; i++) begin
              jolt_r[i] <= 4'd0;
            end
          end
        end
        S_SELECT: begin
          jolt_r <= jolt_next_s;
          idx_r  <= idx_r + LEN_W'(1);
          if (last_idx_s) begin
            p_r    <= P_W'(0);
            bank_r <= BANK_BITS'(0);
          end
        end
        S_PACK: begin
          // x*10 as (x<<3)+(x<<1), then append the next selected digit
          bank_r <= (bank_r << 3) + (bank_r << 1) + BANK_BITS'(jolt_r[p_r]);
          p_r    <= p_r + P_W'(1);
        end
        S_ACCUM: begin
          answer_r     <= sum_s[ANSWER_BITS-1:0];
          bank_count_r <= bank_count_r + 16'd1;
          len_r        <= LEN_W'(0);
          if (|sum_s[SUM_W-1:ANSWER_BITS]) begin
            overflow_r <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign InReady   = in_ready_r;
  assign Answer    = answer_r;
  assign BankCount = bank_count_r;
  assign Overflow  = overflow_r;
  assign Error     = error_r;
  assign Done      = done_r;

endmodule
